// File: rtl/ibex_cap_fetch_fifo.sv
// ibex_cap_fetch_fifo: fetch FIFO between prefetch FSM and ID, carrying address, word and exception records.
// Define FETCH_FIFO_BYPASS_EN to present a push into an empty FIFO combinationally in the same cycle.
module ibex_cap_fetch_fifo #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned EXC_W = 6
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic [31:0]        in_addr_i,
    input  logic [31:0]        in_rdata_i,
    input  logic [2*EXC_W-1:0] in_exc_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [31:0]        out_rdata_o,
    output logic [2*EXC_W-1:0] out_exc_o,
    output logic [31:0]        out_addr_o,
    output logic               out_valid_stored_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [31:0]        addr_q  [DEPTH];
    logic [31:0]        rdata_q [DEPTH];
    logic [2*EXC_W-1:0] exc_q   [DEPTH];
    logic [PW-1:0]      rd_ptr, wr_ptr;
    logic [CW-1:0]      count;
    logic               push, pop, full, stored, byp, wr_en, rd_en;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign full               = count == CW'(DEPTH);
    assign push               = in_valid_i & ~clear_i;
    assign stored             = (count != '0) & ~clear_i;
    assign out_valid_stored_o = stored;
    // One slot stays free for the response already in flight.
    assign in_ready_o         = count <= CW'(DEPTH - 2);
`ifdef FETCH_FIFO_BYPASS_EN
    assign byp = push & (count == '0);
`else
    assign byp = 1'b0;
`endif
    assign out_valid_o = stored | byp;
    assign out_addr_o  = byp ? in_addr_i  : addr_q[rd_ptr];
    assign out_rdata_o = byp ? in_rdata_i : rdata_q[rd_ptr];
    assign out_exc_o   = byp ? in_exc_i   : exc_q[rd_ptr];
    assign pop         = out_valid_o & out_ready_i & ~clear_i;
    assign rd_en       = pop & stored;
    // A bypassed beat consumed in the same cycle never touches storage.
    assign wr_en       = push & ~full & ~(byp & pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= '0;
                rdata_q[i] <= '0;
                exc_q[i]   <= '0;
            end
        end else if (clear_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                addr_q[wr_ptr]  <= in_addr_i;
                rdata_q[wr_ptr] <= in_rdata_i;
                exc_q[wr_ptr]   <= in_exc_i;
                wr_ptr          <= inc(wr_ptr);
            end
            if (rd_en) rd_ptr <= inc(rd_ptr);
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

    push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && full));
endmodule
